// File: rtl/analog_pin_pkg.sv
// analog_pin_pkg: shared widths, scheduler state type and the 2-of-3 majority vote.
package analog_pin_pkg;
    localparam int DIG_W = 12;
    localparam int ANA_W = 6;
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, RESP} sched_state_t;
    function automatic logic [ANA_W-1:0] maj3(input logic [ANA_W-1:0] a, input logic [ANA_W-1:0] b,
                                              input logic [ANA_W-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/analog_pin_scheduler_sync.sv
// pin_sync: 2-flop synchronizer with synchronous reset for asynchronous fabric returns.
module pin_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/analog_pin_scheduler.sv
// analog_pin_scheduler: drives a pattern, settles, majority-votes 3 analog samples, returns result.
// Optional error counter ports err_clr/err_count when ANALOG_SCHED_ERRCNT_EN is defined.
module analog_pin_scheduler
    import analog_pin_pkg::*;
#(
    parameter int               SETTLE_CYCLES = 8,
    parameter logic [DIG_W-1:0] PARK_VALUE    = 12'h000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [DIG_W-1:0] req_pattern,
    input  logic [ANA_W-1:0] req_expect,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ANA_W-1:0] rsp_sample,
    output logic             rsp_mismatch,
    output logic [DIG_W-1:0] pin_digital,
    input  logic [ANA_W-1:0] pin_analog,
`ifdef ANALOG_SCHED_ERRCNT_EN
    input  logic             err_clr,
    output logic [15:0]      err_count,
`endif
    output logic             busy
);
    localparam int CW = $clog2(SETTLE_CYCLES);

    generate
        if (SETTLE_CYCLES < 3) begin : g_bad_settle
            $error("analog_pin_scheduler: SETTLE_CYCLES must be >= 3");
        end
    endgenerate

    sched_state_t     state;
    logic [CW-1:0]    cnt;
    logic [1:0]       scnt;
    logic [ANA_W-1:0] sync, s0, s1, expv, vote;

    pin_sync #(.W(ANA_W)) u_sync (.clk(clk), .rst(rst), .d(pin_analog), .q(sync));

    // third sample is taken straight from the synchronizer so the vote registers on the last SAMPLE edge
    assign vote = maj3(s0, s1, sync);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pin_digital  <= PARK_VALUE;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_sample   <= '0;
            rsp_mismatch <= 1'b0;
            busy         <= 1'b0;
            cnt          <= '0;
            scnt         <= '0;
            s0           <= '0;
            s1           <= '0;
            expv         <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    pin_digital <= req_pattern;
                    expv        <= req_expect;
                    cnt         <= CW'(SETTLE_CYCLES - 1);
                    req_ready   <= 1'b0;
                    busy        <= 1'b1;
                    state       <= DRIVE;
                end
                DRIVE: if (cnt == '0) begin
                    scnt  <= '0;
                    state <= SAMPLE;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                SAMPLE: begin
                    scnt <= scnt + 1'b1;
                    if (scnt == 2'd0) s0 <= sync;
                    if (scnt == 2'd1) s1 <= sync;
                    if (scnt == 2'd2) begin
                        rsp_sample   <= vote;
                        rsp_mismatch <= vote != expv;
                        rsp_valid    <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: if (rsp_ready) begin
                    rsp_valid   <= 1'b0;
                    pin_digital <= PARK_VALUE;
                    req_ready   <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ANALOG_SCHED_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst || err_clr) err_count <= '0;
        else if (rsp_valid && rsp_ready && rsp_mismatch && err_count != 16'hFFFF) err_count <= err_count + 1'b1;
    end
`endif
endmodule
